// File: rtl/kbd_io_responder.sv
// kbd_io_responder: Wishbone key-matrix/PIA/VIA shadow window driving the PET keyboard row byte.
// Optional KBD_IO_DIRTY_EN adds a per-shadow dirty vector and io_dirty_o.
module kbd_io_responder #(
  parameter int KBD_COLS = 10,
  parameter int REG_AW   = 5
) (
  input  logic              wb_clock_i,
  input  logic              wb_reset_i,
  input  logic [19:0]       wb_addr_i,
  input  logic [7:0]        wb_data_i,
  output logic [7:0]        wb_data_o,
  input  logic              wb_we_i,
  input  logic              wb_cycle_i,
  input  logic              wb_strobe_i,
  output logic              wb_stall_o,
  output logic              wb_ack_o,
  input  logic              cpu_wr_i,
  input  logic [REG_AW-1:0] cpu_reg_i,
  input  logic [7:0]        cpu_data_i,
`ifdef KBD_IO_DIRTY_EN
  output logic              io_dirty_o,
`endif
  output logic [7:0]        kbd_row_o
);
  localparam logic [REG_AW-1:0] COLS  = REG_AW'(KBD_COLS);
  localparam logic [REG_AW-1:0] SH_LO = REG_AW'(16);
  localparam logic [REG_AW-1:0] SH_HI = REG_AW'(24);
  logic [REG_AW-1:0] idx;
  logic accept, wb_is_col, wb_is_sh, cpu_is_sh, ack_q, ack_d;
  logic [3:0] wb_sh, cpu_sh, col;
  logic [KBD_COLS-1:0][7:0] matrix_q, matrix_d;
  logic [8:0][7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d, row_q, row_d;
  assign idx        = wb_addr_i[REG_AW-1:0];
  assign accept     = wb_cycle_i & wb_strobe_i;
  assign wb_is_col  = idx < COLS;
  assign wb_is_sh   = idx >= SH_LO && idx <= SH_HI;
  assign cpu_is_sh  = cpu_reg_i >= SH_LO && cpu_reg_i <= SH_HI;
  assign wb_sh      = 4'(idx - SH_LO);
  assign cpu_sh     = 4'(cpu_reg_i - SH_LO);
  // Shadow 0 is PIA1 PORTA; its low nibble selects the scanned column.
  assign col        = shadow_q[0][3:0];
  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_data_o  = data_q;
  assign kbd_row_o  = row_q;
  always_comb begin
    matrix_d = matrix_q;
    shadow_d = shadow_q;
    if (accept && wb_we_i && wb_is_col) matrix_d[idx[3:0]] = wb_data_i;
    if (cpu_wr_i && cpu_is_sh) shadow_d[cpu_sh] = cpu_data_i;
    ack_d  = accept;
    data_d = !accept ? data_q : wb_is_col ? matrix_q[idx[3:0]] : wb_is_sh ? shadow_q[wb_sh] : 8'hFF;
    row_d  = ({1'b0, col} < 5'(KBD_COLS)) ? matrix_q[col] : 8'hFF;
  end
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      matrix_q <= '1;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      data_q   <= 8'h00;
      row_q    <= 8'hFF;
    end else begin
      matrix_q <= matrix_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      row_q    <= row_d;
    end
  end
`ifdef KBD_IO_DIRTY_EN
  logic [8:0] dirty_q, dirty_d;
  logic io_dirty_q;
  // Clear on read is applied first so a coincident snoop set wins.
  always_comb begin
    dirty_d = dirty_q;
    if (accept && !wb_we_i && wb_is_sh) dirty_d[wb_sh] = 1'b0;
    if (cpu_wr_i && cpu_is_sh) dirty_d[cpu_sh] = 1'b1;
  end
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      dirty_q    <= '0;
      io_dirty_q <= 1'b0;
    end else begin
      dirty_q    <= dirty_d;
      io_dirty_q <= |dirty_q;
    end
  end
  assign io_dirty_o = io_dirty_q;
`endif
endmodule

// File: tb/tb_kbd_io_responder.sv
// tb_kbd_io_responder: directed self-checking bench for kbd_io_responder.
module tb_kbd_io_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic [19:0] addr = '0;
  logic [7:0] wdata = '0, rdata, cpu_d = '0, row;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0, stall, ack, cpu_wr = 1'b0;
  logic [4:0] cpu_reg = '0;
  int n_cmp = 0, n_err = 0;
`ifdef KBD_IO_DIRTY_EN
  logic io_dirty;
`endif
  always #5 clk = ~clk;
  kbd_io_responder dut (
    .wb_clock_i(clk), .wb_reset_i(rst), .wb_addr_i(addr), .wb_data_i(wdata),
    .wb_data_o(rdata), .wb_we_i(we), .wb_cycle_i(cyc), .wb_strobe_i(stb),
    .wb_stall_o(stall), .wb_ack_o(ack), .cpu_wr_i(cpu_wr), .cpu_reg_i(cpu_reg),
    .cpu_data_i(cpu_d),
`ifdef KBD_IO_DIRTY_EN
    .io_dirty_o(io_dirty),
`endif
    .kbd_row_o(row)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wb_op(input logic w, input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp, input string tag);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = {15'd0, a}; wdata = d;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    chk({tag, " ack"}, ack, 1);
    if (!w) chk({tag, " data"}, rdata, exp);
    @(negedge clk);
    chk({tag, " ack1cyc"}, ack, 0);
  endtask
  task automatic snoop(input logic [4:0] r, input logic [7:0] d);
    @(negedge clk);
    cpu_wr = 1; cpu_reg = r; cpu_d = d;
    @(negedge clk);
    cpu_wr = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst ack", ack, 0);
    chk("rst data", rdata, 8'h00);
    chk("rst row", row, 8'hFF);
    chk("stall", stall, 0);
    rst = 0;
    wb_op(0, 0, 0, 8'hFF, "rd0");
    wb_op(0, 9, 0, 8'hFF, "rd9");
    wb_op(0, 10, 0, 8'hFF, "rd10");
    wb_op(0, 16, 0, 8'h00, "rd16");
    wb_op(1, 12, 8'h00, 0, "wr12");
    wb_op(0, 12, 0, 8'hFF, "rd12");
    wb_op(0, 25, 0, 8'hFF, "rd25");
    wb_op(1, 3, 8'hFE, 0, "wr3");
    snoop(16, 8'h03);
    chk("row lat", row, 8'hFF);
    @(negedge clk);
    chk("row col3", row, 8'hFE);
    snoop(16, 8'h0C);
    chk("row hold", row, 8'hFE);
    @(negedge clk);
    chk("row colC", row, 8'hFF);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 20'd0; wdata = 8'h7F;
    @(negedge clk);
    chk("b2b ack0", ack, 1);
    we = 0; addr = 20'd0;
    @(negedge clk);
    chk("b2b ack1", ack, 1);
    chk("b2b rd col0", rdata, 8'h7F);
    we = 1; addr = 20'd24; wdata = 8'h55;
    @(negedge clk);
    chk("b2b ack2", ack, 1);
    we = 0; addr = 20'd24;
    @(negedge clk);
    cyc = 0; stb = 0;
    chk("b2b ack3", ack, 1);
    chk("b2b rd 24", rdata, 8'h00);
    @(negedge clk);
    chk("b2b end", ack, 0);
    cyc = 1; stb = 1; we = 0; addr = 20'd24;
    cpu_wr = 1; cpu_reg = 24; cpu_d = 8'hA5;
    @(negedge clk);
    cyc = 0; stb = 0; cpu_wr = 0;
    chk("same ack", ack, 1);
    chk("same old", rdata, 8'h00);
    wb_op(0, 24, 0, 8'hA5, "rd24 new");
`ifdef KBD_IO_DIRTY_EN
    wb_op(0, 16, 0, 8'h0C, "clr16");
    @(negedge clk);
    chk("dirty clear", io_dirty, 0);
    snoop(20, 8'h12);
    @(negedge clk);
    chk("dirty set", io_dirty, 1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = 20'd20;
    @(negedge clk);
    cyc = 0; stb = 0;
    chk("d rd ack", ack, 1);
    chk("d rd data", rdata, 8'h12);
    chk("d at ack", io_dirty, 1);
    @(negedge clk);
    chk("d after ack", io_dirty, 0);
    cyc = 1; stb = 1; we = 0; addr = 20'd20;
    cpu_wr = 1; cpu_reg = 20; cpu_d = 8'h34;
    @(negedge clk);
    cyc = 0; stb = 0; cpu_wr = 0;
    chk("d2 data", rdata, 8'h12);
    repeat (2) @(negedge clk);
    chk("d set wins", io_dirty, 1);
    @(negedge clk);
    chk("d stays", io_dirty, 1);
`endif
    snoop(16, 8'h03);
    repeat (2) @(negedge clk);
    chk("pre rst row", row, 8'hFE);
    cyc = 1; stb = 1; we = 0; addr = 20'd3;
    @(negedge clk);
    cyc = 0; stb = 0;
    chk("pend ack", ack, 1);
    rst = 1;
    #1 chk("rst kills ack", ack, 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = 20'd3; rst = 1;
    @(negedge clk);
    cyc = 0; stb = 0; rst = 0;
    chk("rst no ack", ack, 0);
    @(negedge clk);
    chk("rst no ack2", ack, 0);
    chk("rst row2", row, 8'hFF);
`ifdef KBD_IO_DIRTY_EN
    chk("rst dirty", io_dirty, 0);
`endif
    wb_op(0, 3, 0, 8'hFF, "rst mat3");
    wb_op(0, 16, 0, 8'h00, "rst sh16");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
